// File: rtl/pwm_led_bar_pkg.sv
// Shared types and constant helpers for the PWM LED bar block.
package pwm_led_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last value of the period counter; a period spans cnt_max+1 = 2**width-1 ticks.
    function automatic int cnt_max(input int width);
        return (32'sd1 <<< width) - 32'sd2;
    endfunction

    // Segment i lights when duty*num_leds exceeds i*(2**width-1).
    // Indices at or beyond num_leds get the largest possible product, so they never light.
    function automatic int bar_threshold(input int i, input int width, input int num_leds);
        int full_scale;
        full_scale = (32'sd1 <<< width) - 32'sd1;
        if (i >= num_leds) begin
            return num_leds * full_scale;
        end else begin
            return i * full_scale;
        end
    endfunction

endpackage

// File: rtl/pwm_led_bar_if.sv
// Control/status bundle between the duty source and the PWM LED bar block.
interface pwm_led_bar_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_LEDS = 8
);
    logic                en;
    logic [WIDTH-1:0]    duty;
    logic                duty_load;
    logic                pwm_out;
    logic                period_start;
    logic [WIDTH-1:0]    duty_active;
    logic [NUM_LEDS-1:0] led;

    modport master (
        output en, duty, duty_load,
        input  pwm_out, period_start, duty_active, led
    );

    modport slave (
        input  en, duty, duty_load,
        output pwm_out, period_start, duty_active, led
    );
endinterface

// File: rtl/pwm_led_bar_prescaler.sv
// Tick generator: one tick every PRESCALE clock cycles, held cleared by clr.
module pwm_prescaler
    import pwm_led_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;

    // Next prescaler count: restart on clear or after the last count.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PW'(32'd1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign tick = !clr && (pre_cnt_q == PRE_LAST);

endmodule

// File: rtl/pwm_led_bar.sv
// PWM generator with shadowed duty and a registered thermometer LED bar.
// Build option: define PWM_LED_BAR_DIM_EN to gate the bar with the PWM output
// (LED brightness follows duty); otherwise the bar is a static thermometer.
module pwm_led_bar
    import pwm_led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_LEDS = 8,
    parameter int PRESCALE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    pwm_led_bar_if.slave  bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));
    // Wide enough for duty*NUM_LEDS without overflow.
    localparam int               PW      = WIDTH + $clog2(NUM_LEDS) + 1;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic [WIDTH-1:0]    duty_active_q, duty_active_d;
    logic                pwm_q, pwm_d;
    logic                period_start_q, period_start_d;
    logic [NUM_LEDS-1:0] led_q, led_d;

    logic                tick_s;
    logic                clr_s;
    logic [PW-1:0]       prod_s;
    logic [NUM_LEDS-1:0] bar_s;

    // Prescaler is frozen at zero while idle and on the cycle en drops, so a
    // fresh run always starts with a full-length first tick.
    assign clr_s = (state_q == IDLE) || !bus.en;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // FSM next state, period counter, active duty and PWM compare.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        duty_active_d  = duty_active_q;
        period_start_d = 1'b0;
        pwm_d          = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d         = '0;
                duty_active_d = shadow_q;
                if (bus.en) begin
                    state_d        = RUN;
                    period_start_d = 1'b1;
                end else begin
                    state_d        = IDLE;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    pwm_d = (cnt_q < duty_active_q);
                    if (tick_s && (cnt_q == CNT_MAX)) begin
                        // Period boundary: a load landing on this very cycle
                        // skips the shadow so it governs the next period.
                        cnt_d          = '0;
                        period_start_d = 1'b1;
                        duty_active_d  = bus.duty_load ? bus.duty : shadow_q;
                    end else if (tick_s) begin
                        cnt_d = cnt_q + WIDTH'(32'd1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Shadow register: last load wins.
    always_comb begin
        if (bus.duty_load) begin
            shadow_d = bus.duty;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Thermometer encoder on the duty currently in effect.
    always_comb begin
        prod_s = PW'(duty_active_q) * PW'(NUM_LEDS);
        bar_s  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            bar_s[i] = (prod_s > PW'(bar_threshold(i, WIDTH, NUM_LEDS)));
        end
    end

    // LED drive: gating uses pwm_d so the LEDs line up with the registered pwm_out.
    always_comb begin
`ifdef PWM_LED_BAR_DIM_EN
        led_d = bar_s & {NUM_LEDS{pwm_d}};
`else
        led_d = bar_s;
`endif
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shadow_q       <= '0;
            duty_active_q  <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            led_q          <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            duty_active_q  <= duty_active_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            led_q          <= led_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.duty_active  = duty_active_q;
    assign bus.led          = led_q;

endmodule
